// File: rtl/prco_mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, STATUS bit layout
// and the UART transmitter state encoding.
package prco_mmio_pkg;

  localparam logic [1:0] MMIO_TXDATA = 2'd0;
  localparam logic [1:0] MMIO_STATUS = 2'd1;
  localparam logic [1:0] MMIO_CYCLES = 2'd2;
  localparam logic [1:0] MMIO_LEDS   = 2'd3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/prco_uart_tx.sv
// 8N1 serial transmitter: pulls one byte at a time from the TX FIFO through a
// pop/data handshake and shifts it out LSB first.
module prco_uart_tx
  import prco_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       fifo_valid,
  input  logic [7:0] fifo_data,
  output logic       pop,
  output logic       q_tx,
  output logic       busy
);

  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              bit_done;

  assign bit_done = (baud == '0);

  // NOTE: state lives in always_ff with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= TX_IDLE;
    else         state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (fifo_valid) state_next = TX_START;
      TX_START: if (bit_done) state_next = TX_DATA;
      TX_DATA:  if (bit_done && bit_idx == 3'd7) state_next = TX_STOP;
      TX_STOP:  if (bit_done) state_next = fifo_valid ? TX_START : TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // A queued byte is taken straight from the end of a stop bit so frames run back to back.
  always_comb begin
    q_tx = 1'b1;
    busy = 1'b1;
    pop  = 1'b0;
    case (state)
      TX_IDLE: begin
        busy = 1'b0;
        pop  = fifo_valid;
      end
      TX_START: q_tx = 1'b0;
      TX_DATA:  q_tx = shreg[0];
      TX_STOP:  pop = bit_done & fifo_valid;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      baud    <= BAUD_RELOAD;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else if (pop) begin
      baud    <= BAUD_RELOAD;
      bit_idx <= 3'd0;
      shreg   <= fifo_data;
    end else if (state != TX_IDLE) begin
      if (bit_done) begin
        baud <= BAUD_RELOAD;
        if (state == TX_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud <= baud - 1'b1;
      end
    end
  end

endmodule

// File: rtl/prco_mmio.sv
// Memory-mapped I/O responder: UART TX FIFO, free-running cycle counter and LED
// register, answering hit requests two cycles later like a local-memory read.
module prco_mmio
  import prco_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_din,
  output logic        q_hit,
  output logic        q_ce_reg,
  output logic [15:0] q_dout,
  output logic        q_tx,
  output logic [7:0]  q_leds
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]       offset;
  logic             accept;
  logic             wr_txdata;
  logic             wr_cycles;
  logic             wr_leds;
  logic             rd_status;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             overflow;
  logic             overflow_set;
  logic             tx_busy;

  logic [15:0]      cycles;
  logic [15:0]      status;
  logic [15:0]      rd_data;

  logic             s1_valid;
  logic [15:0]      s1_data;
  logic             s2_valid;
  logic [15:0]      s2_data;

  assign offset = i_addr[1:0];
  assign q_hit  = (i_addr[15:2] == BASE_ADDR[15:2]);
  assign accept = i_ce & q_hit;

  assign wr_txdata = accept &  i_we & (offset == MMIO_TXDATA);
  assign wr_cycles = accept &  i_we & (offset == MMIO_CYCLES);
  assign wr_leds   = accept &  i_we & (offset == MMIO_LEDS);
  assign rd_status = accept & ~i_we & (offset == MMIO_STATUS);

  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  // A full FIFO still takes a byte when the transmitter drains one on the same edge.
  assign push         = wr_txdata & (~fifo_full | pop);
  assign overflow_set = wr_txdata & ~push;

  // NOTE: the FIFO storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_din[7:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (overflow_set)   overflow <= 1'b1;
      else if (rd_status) overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cycles <= 16'h0000;
      q_leds <= 8'h00;
    end else begin
      cycles <= wr_cycles ? i_din : cycles + 16'd1;
      if (wr_leds) q_leds <= i_din[7:0];
    end
  end

  prco_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .fifo_valid(~fifo_empty),
    .fifo_data (fifo_mem[rd_ptr]),
    .pop       (pop),
    .q_tx      (q_tx),
    .busy      (tx_busy)
  );

  always_comb begin
    status = 16'h0000;
    status[STAT_FULL]     = fifo_full;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_BUSY]     = tx_busy;
    status[STAT_OVERFLOW] = overflow;
    status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
  end

  // Read data is captured from pre-edge state; writes answer with zero.
  always_comb begin
    rd_data = 16'h0000;
    if (!i_we) begin
      case (offset)
        MMIO_STATUS: rd_data = status;
        MMIO_CYCLES: rd_data = cycles;
        MMIO_LEDS:   rd_data = {8'h00, q_leds};
        default:     rd_data = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_data  <= 16'h0000;
      s2_valid <= 1'b0;
      s2_data  <= 16'h0000;
      q_ce_reg <= 1'b0;
      q_dout   <= 16'h0000;
    end else begin
      s1_valid <= accept;
      s1_data  <= rd_data;
      s2_valid <= s1_valid;
      s2_data  <= s1_data;
      q_ce_reg <= s2_valid;
      if (s2_valid) q_dout <= s2_data;
    end
  end

endmodule

// File: tb/tb_prco_mmio.sv
// Directed bench for prco_mmio with a short UART bit time: register map, response
// latency, 8N1 framing, FIFO overflow, counter wrap, address decode and reset.
module tb_prco_mmio;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int          CPB  = 4;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_ce    = 1'b0;
  logic        i_we    = 1'b0;
  logic [15:0] i_addr  = 16'h0000;
  logic [15:0] i_din   = 16'h0000;
  logic        q_hit;
  logic        q_ce_reg;
  logic [15:0] q_dout;
  logic        q_tx;
  logic [7:0]  q_leds;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  prco_mmio #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_din   (i_din),
    .q_hit   (q_hit),
    .q_ce_reg(q_ce_reg),
    .q_dout  (q_dout),
    .q_tx    (q_tx),
    .q_leds  (q_leds)
  );

  // Called at a falling edge; the request is sampled on the next rising edge and
  // the task returns at the falling edge after it.
  task automatic mmio_req(input logic we, input logic [15:0] addr, input logic [15:0] din);
    i_ce   = 1'b1;
    i_we   = we;
    i_addr = addr;
    i_din  = din;
    @(negedge i_clk);
    i_ce = 1'b0;
    i_we = 1'b0;
  endtask

  // Request plus bounded wait for the response; lat is in cycles, -1 if none came.
  task automatic mmio_xact(input logic we, input logic [15:0] addr, input logic [15:0] din,
                           output logic [15:0] dout, output int lat);
    mmio_req(we, addr, din);
    lat  = -1;
    dout = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      if (q_ce_reg === 1'b1) begin
        lat  = k;
        dout = q_dout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int          bad_tx;
    int          bad_ce;
    int          lat;
    logic [15:0] d;
    #2 i_reset = 1'b1;
    #10;
    checks++; if (q_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", q_tx); end
    checks++; if (q_ce_reg !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", q_ce_reg); end
    checks++; if (q_dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", q_dout); end
    checks++; if (q_leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h expected 00", q_leds); end
    @(negedge i_clk);
    i_reset = 1'b0;
    bad_tx = 0;
    bad_ce = 0;
    repeat (100) begin
      @(negedge i_clk);
      if (q_tx !== 1'b1) bad_tx++;
      if (q_ce_reg !== 1'b0) bad_ce++;
    end
    checks++; if (bad_tx !== 0) begin errors++; $display("FAIL idle_tx: %0d cycles not high, expected 0", bad_tx); end
    checks++; if (bad_ce !== 0) begin errors++; $display("FAIL idle_ce: %0d spurious pulses, expected 0", bad_ce); end
    mmio_xact(1'b0, BASE + 16'd1, 16'h0000, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL status_latency: got %0d expected 2", lat); end
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_reset: got %h expected 0002", d); end
  endtask

  task automatic test_tx_frame();
    logic [9:0]  frame;
    int          lat;
    logic [15:0] d;
    frame = {1'b1, 8'hA5, 1'b0};
    mmio_req(1'b1, BASE, 16'h00A5);
    checks++; if (q_tx !== 1'b1) begin errors++; $display("FAIL tx_before_start: got %b expected 1", q_tx); end
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge i_clk);
      checks++;
      if (q_tx !== frame[i / CPB]) begin
        errors++;
        $display("FAIL tx_bit cycle %0d: got %b expected %b", i, q_tx, frame[i / CPB]);
      end
      if (i == 1) begin
        checks++;
        if (q_ce_reg !== 1'b1 || q_dout !== 16'h0000) begin
          errors++;
          $display("FAIL txdata_write_rsp: got ce=%b dout=%h expected ce=1 dout=0000", q_ce_reg, q_dout);
        end
      end
    end
    mmio_xact(1'b0, BASE + 16'd1, 16'h0000, d, lat);
    checks++; if (d !== 16'h0006) begin errors++; $display("FAIL status_last_stop: got %h expected 0006", d); end
    mmio_xact(1'b0, BASE + 16'd1, 16'h0000, d, lat);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_after_frame: got %h expected 0002", d); end
  endtask

  task automatic test_cycles();
    int          lat;
    logic [15:0] d;
    mmio_req(1'b1, BASE + 16'd2, 16'hFFFE);
    repeat (3) @(negedge i_clk);
    mmio_xact(1'b0, BASE + 16'd2, 16'h0000, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL cycles_latency: got %0d expected 2", lat); end
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL cycles_wrap: got %h expected 0001", d); end
  endtask

  task automatic test_leds();
    int          lat;
    logic [15:0] d;
    mmio_xact(1'b1, BASE + 16'd3, 16'h12C3, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL leds_write_latency: got %0d expected 2", lat); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL leds_write_dout: got %h expected 0000", d); end
    checks++; if (q_leds !== 8'hC3) begin errors++; $display("FAIL leds_port: got %h expected c3", q_leds); end
    mmio_xact(1'b0, BASE + 16'd3, 16'h0000, d, lat);
    checks++; if (d !== 16'h00C3) begin errors++; $display("FAIL leds_read: got %h expected 00c3", d); end
  endtask

  task automatic test_no_hit();
    int          pulses;
    int          lat;
    logic [15:0] d;
    i_addr = BASE + 16'd4;
    #1 checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL hit_above: got %b expected 0", q_hit); end
    i_addr = BASE + 16'd3;
    #1 checks++; if (q_hit !== 1'b1) begin errors++; $display("FAIL hit_top: got %b expected 1", q_hit); end
    i_addr = BASE - 16'd1;
    #1 checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL hit_below: got %b expected 0", q_hit); end
    mmio_req(1'b1, BASE + 16'd4, 16'h0077);
    mmio_req(1'b1, BASE - 16'd1, 16'h0055);
    mmio_req(1'b0, BASE + 16'd4, 16'h0000);
    pulses = 0;
    repeat (6) begin
      if (q_ce_reg !== 1'b0) pulses++;
      @(negedge i_clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL nohit_rsp: got %0d responses expected 0", pulses); end
    checks++; if (q_leds !== 8'hC3) begin errors++; $display("FAIL nohit_leds: got %h expected c3", q_leds); end
    checks++; if (q_tx !== 1'b1) begin errors++; $display("FAIL nohit_tx: got %b expected 1", q_tx); end
    mmio_xact(1'b0, BASE + 16'd1, 16'h0000, d, lat);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL nohit_status: got %h expected 0002", d); end
  endtask

  task automatic test_back_to_back();
    int          pulses;
    int          lat;
    logic [15:0] d;
    mmio_req(1'b1, BASE, 16'h0000);
    repeat (3) @(negedge i_clk);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      if (q_ce_reg === 1'b1) pulses++;
      mmio_req(1'b1, BASE, 16'(16 + i));
    end
    for (int i = 0; i < 3; i++) begin
      if (q_ce_reg === 1'b1) pulses++;
      @(negedge i_clk);
    end
    checks++; if (pulses !== 9) begin errors++; $display("FAIL burst_responses: got %0d expected 9", pulses); end
    mmio_xact(1'b0, BASE + 16'd1, 16'h0000, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL overflow_latency: got %0d expected 2", lat); end
    checks++; if (d !== 16'h080D) begin errors++; $display("FAIL overflow_status: got %h expected 080d", d); end
    mmio_xact(1'b0, BASE + 16'd1, 16'h0000, d, lat);
    checks++; if (d !== 16'h0805) begin errors++; $display("FAIL overflow_cleared: got %h expected 0805", d); end
  endtask

  task automatic test_reset_mid_frame();
    int          pulses;
    int          bad_tx;
    int          lat;
    logic [15:0] d;
    mmio_req(1'b0, BASE + 16'd3, 16'h0000);
    checks++; if (q_tx !== 1'b0) begin errors++; $display("FAIL midframe_data: got %b expected 0", q_tx); end
    #2 i_reset = 1'b1;
    #1;
    checks++; if (q_tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", q_tx); end
    checks++; if (q_dout !== 16'h0000) begin errors++; $display("FAIL midreset_dout: got %h expected 0000", q_dout); end
    checks++; if (q_leds !== 8'h00) begin errors++; $display("FAIL midreset_leds: got %h expected 00", q_leds); end
    @(negedge i_clk);
    i_reset = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (q_ce_reg !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL pending_discard: got %0d responses expected 0", pulses); end
    mmio_xact(1'b0, BASE + 16'd2, 16'h0000, d, lat);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL cycles_after_reset: got %h expected 0004", d); end
    mmio_xact(1'b0, BASE + 16'd1, 16'h0000, d, lat);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL status_after_reset: got %h expected 0002", d); end
    bad_tx = 0;
    repeat (50) begin
      @(negedge i_clk);
      if (q_tx !== 1'b1) bad_tx++;
    end
    checks++; if (bad_tx !== 0) begin errors++; $display("FAIL tx_after_reset: %0d cycles not high, expected 0", bad_tx); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_cycles();
    test_leds();
    test_no_hit();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
